// File: rtl/control_sequencer_if.sv
// Strobe and handshake bundle between the hardwired control sequencer and the DataPath.
// The sequencer is the master: it consumes IR/mem_ready/Stop and drives every strobe.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        mem_ready;
  logic        Stop;

  logic        PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout;
  logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high;
  logic        IncPC, Read;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [3:0]  operation;
  logic        Run, illegal_op, mem_fault;

  modport master (
    input  IR, mem_ready, Stop,
    output PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout,
    output MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
    output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
    output operation, Run, illegal_op, mem_fault
  );

  modport slave (
    output IR, mem_ready, Stop,
    input  PCout, Zlowout, Zhighout, HIout, LOout, MDRout, Cout,
    input  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high,
    input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
    input  operation, Run, illegal_op, mem_fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and execute (T3-T6) of the ALU instruction subset,
// with a ready/timeout handshake on the memory read and HALT/FAULT terminal states.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                 Clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    RST   = 4'd0,
    T0    = 4'd1,
    T1    = 4'd2,
    T2    = 4'd3,
    T3    = 4'd4,
    T4    = 4'd5,
    T5    = 4'd6,
    T6    = 4'd7,
    HALT  = 4'd8,
    FAULT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_REG3   = 3'd1,
    C_IMM    = 3'd2,
    C_MULDIV = 3'd3,
    C_UNARY  = 3'd4,
    C_NOP    = 3'd5,
    C_HALT   = 3'd6
  } iclass_t;

  function automatic iclass_t classify(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: classify = C_REG3;
      5'b01011, 5'b01100, 5'b01101:           classify = C_IMM;
      5'b01111, 5'b10000:                     classify = C_MULDIV;
      5'b10001, 5'b10010:                     classify = C_UNARY;
      5'b11010:                               classify = C_NOP;
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_NONE;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] opc);
    case (opc)
      5'b00011: alu_code = 4'b0001;
      5'b00100: alu_code = 4'b0010;
      5'b00101: alu_code = 4'b0011;
      5'b00110: alu_code = 4'b0100;
      5'b00111: alu_code = 4'b0101;
      5'b01000: alu_code = 4'b0110;
      5'b01001: alu_code = 4'b0111;
      5'b01010: alu_code = 4'b1000;
      5'b01011: alu_code = 4'b0001;
      5'b01100: alu_code = 4'b0011;
      5'b01101: alu_code = 4'b0100;
      5'b01111: alu_code = 4'b1001;
      5'b10000: alu_code = 4'b1010;
      5'b10001: alu_code = 4'b1011;
      5'b10010: alu_code = 4'b1100;
      default:  alu_code = 4'b0000;
    endcase
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [4:0]         opcode_s;
  iclass_t            iclass_s;
  logic [3:0]         alu_op_s;
  logic               last_exec_s;
  logic               timeout_s;

  assign opcode_s  = bus.IR[31:27];
  assign iclass_s  = classify(opcode_s);
  assign alu_op_s  = alu_code(opcode_s);
  assign timeout_s = (MEM_TIMEOUT != 32'd0) && (32'(wait_cnt_r) == (MEM_TIMEOUT - 32'd1));

  // Final execute step of the current class; a class with no execute phase aborts to T0.
  always_comb begin
    last_exec_s = 1'b0;
    case (iclass_s)
      C_REG3, C_IMM: last_exec_s = (state_r == T5);
      C_UNARY:       last_exec_s = (state_r == T4);
      C_MULDIV:      last_exec_s = (state_r == T6);
      default:       last_exec_s = 1'b1;
    endcase
  end

  // Sequencer state and T1 wait counter.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_r    <= RST;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        RST: state_r <= T0;
        T0: begin
          state_r    <= T1;
          wait_cnt_r <= '0;
        end
        T1: begin
          if (bus.mem_ready) begin
            state_r <= T2;
          end else if (timeout_s) begin
            state_r <= FAULT;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          end
        end
        T2: begin
          case (iclass_s)
            C_NOP:   state_r <= T0;
            C_HALT:  state_r <= HALT;
            C_NONE:  state_r <= T0;
            default: state_r <= T3;
          endcase
        end
        T3: state_r <= last_exec_s ? (bus.Stop ? HALT : T0) : T4;
        T4: state_r <= last_exec_s ? (bus.Stop ? HALT : T0) : T5;
        T5: state_r <= last_exec_s ? (bus.Stop ? HALT : T0) : T6;
        T6: state_r <= bus.Stop ? HALT : T0;
        HALT:  state_r <= HALT;
        FAULT: state_r <= FAULT;
        default: state_r <= RST;
      endcase
    end
  end

  // Strobe decode; PCin/Zlowout in T1 follow mem_ready so the PC update lands with the data.
  always_comb begin
    bus.PCout     = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.HIout     = 1'b0;
    bus.LOout     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.Cout      = 1'b0;
    bus.MARin     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDRin     = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
    bus.Zin_low   = 1'b0;
    bus.Zin_high  = 1'b0;
    bus.IncPC     = 1'b0;
    bus.Read      = 1'b0;
    bus.Gra       = 1'b0;
    bus.Grb       = 1'b0;
    bus.Grc       = 1'b0;
    bus.Rin       = 1'b0;
    bus.Rout      = 1'b0;
    bus.operation = 4'b0000;
    bus.illegal_op = 1'b0;
    bus.Run       = (state_r != RST) && (state_r != HALT) && (state_r != FAULT);
    bus.mem_fault = (state_r == FAULT);
    case (state_r)
      T0: begin
        bus.PCout   = 1'b1;
        bus.MARin   = 1'b1;
        bus.IncPC   = 1'b1;
        bus.Zin_low = 1'b1;
      end
      T1: begin
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        bus.Zlowout = bus.mem_ready;
        bus.PCin    = bus.mem_ready;
      end
      T2: begin
        bus.MDRout     = 1'b1;
        bus.IRin       = 1'b1;
        bus.illegal_op = (iclass_s == C_NONE);
      end
      T3: begin
        case (iclass_s)
          C_REG3, C_IMM: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          C_UNARY: begin
            bus.Grb       = 1'b1;
            bus.Rout      = 1'b1;
            bus.operation = alu_op_s;
            bus.Zin_low   = 1'b1;
          end
          C_MULDIV: begin
            bus.Gra  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
          end
          default: bus.operation = 4'b0000;
        endcase
      end
      T4: begin
        case (iclass_s)
          C_REG3: begin
            bus.Grc       = 1'b1;
            bus.Rout      = 1'b1;
            bus.operation = alu_op_s;
            bus.Zin_low   = 1'b1;
          end
          C_IMM: begin
            bus.Cout      = 1'b1;
            bus.operation = alu_op_s;
            bus.Zin_low   = 1'b1;
          end
          C_UNARY: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MULDIV: begin
            bus.Grb       = 1'b1;
            bus.Rout      = 1'b1;
            bus.operation = alu_op_s;
            bus.Zin_low   = 1'b1;
            bus.Zin_high  = 1'b1;
          end
          default: bus.operation = 4'b0000;
        endcase
      end
      T5: begin
        case (iclass_s)
          C_REG3, C_IMM: begin
            bus.Zlowout = 1'b1;
            bus.Gra     = 1'b1;
            bus.Rin     = 1'b1;
          end
          C_MULDIV: begin
            bus.Zlowout = 1'b1;
            bus.LOin    = 1'b1;
          end
          default: bus.operation = 4'b0000;
        endcase
      end
      T6: begin
        if (iclass_s == C_MULDIV) begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end else begin
          bus.Zhighout = 1'b0;
        end
      end
      default: bus.operation = 4'b0000;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised bench for control_sequencer: an instruction-recipe model predicts every strobe each cycle,
// and directed sequences pin the model against hand-derived values.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear;

  control_sequencer_if bus_if();

  control_sequencer #(.MEM_TIMEOUT(15)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 Clock = ~Clock;

  localparam logic [29:0] M_PCOUT  = 30'b1 << 0;
  localparam logic [29:0] M_ZLO    = 30'b1 << 1;
  localparam logic [29:0] M_ZHI    = 30'b1 << 2;
  localparam logic [29:0] M_MDROUT = 30'b1 << 5;
  localparam logic [29:0] M_COUT   = 30'b1 << 6;
  localparam logic [29:0] M_MARIN  = 30'b1 << 7;
  localparam logic [29:0] M_PCIN   = 30'b1 << 8;
  localparam logic [29:0] M_MDRIN  = 30'b1 << 9;
  localparam logic [29:0] M_IRIN   = 30'b1 << 10;
  localparam logic [29:0] M_YIN    = 30'b1 << 11;
  localparam logic [29:0] M_HIIN   = 30'b1 << 12;
  localparam logic [29:0] M_LOIN   = 30'b1 << 13;
  localparam logic [29:0] M_ZINLO  = 30'b1 << 14;
  localparam logic [29:0] M_ZINHI  = 30'b1 << 15;
  localparam logic [29:0] M_INCPC  = 30'b1 << 16;
  localparam logic [29:0] M_READ   = 30'b1 << 17;
  localparam logic [29:0] M_GRA    = 30'b1 << 18;
  localparam logic [29:0] M_GRB    = 30'b1 << 19;
  localparam logic [29:0] M_GRC    = 30'b1 << 20;
  localparam logic [29:0] M_RIN    = 30'b1 << 21;
  localparam logic [29:0] M_ROUT   = 30'b1 << 22;
  localparam logic [29:0] M_RUN    = 30'b1 << 23;
  localparam logic [29:0] M_ILL    = 30'b1 << 24;
  localparam logic [29:0] M_FAULT  = 30'b1 << 25;

  localparam int K_NONE = 0, K_REG3 = 1, K_IMM = 2, K_MD = 3, K_UN = 4, K_NOP = 5, K_HALT = 6;
  localparam int PH_RST = -1, PH_HALT = 100, PH_FAULT = 101;
  localparam int TIMEOUT = 15;

  int          cls_tab [32];
  logic [3:0]  alu_tab [32];
  logic [29:0] recipe  [7][4];
  logic        rop     [7][4];
  int          rlen    [7];

  int m_phase = PH_RST;
  int m_wait  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [29:0] dut_vec();
    return {bus_if.operation, bus_if.mem_fault, bus_if.illegal_op, bus_if.Run, bus_if.Rout,
            bus_if.Rin, bus_if.Grc, bus_if.Grb, bus_if.Gra, bus_if.Read, bus_if.IncPC,
            bus_if.Zin_high, bus_if.Zin_low, bus_if.LOin, bus_if.HIin, bus_if.Yin, bus_if.IRin,
            bus_if.MDRin, bus_if.PCin, bus_if.MARin, bus_if.Cout, bus_if.MDRout, bus_if.LOout,
            bus_if.HIout, bus_if.Zhighout, bus_if.Zlowout, bus_if.PCout};
  endfunction

  function automatic logic [29:0] model_vec(input int ph, input logic [31:0] ir, input logic mr);
    logic [4:0]  opc;
    int          c;
    logic [29:0] v;
    opc = ir[31:27];
    c   = cls_tab[opc];
    v   = 30'b0;
    if (ph == PH_RST || ph == PH_HALT) return 30'b0;
    if (ph == PH_FAULT) return M_FAULT;
    v = M_RUN;
    if (ph == 0) v = v | M_PCOUT | M_MARIN | M_INCPC | M_ZINLO;
    else if (ph == 1) v = v | M_READ | M_MDRIN | (mr ? (M_ZLO | M_PCIN) : 30'b0);
    else if (ph == 2) v = v | M_MDROUT | M_IRIN | ((c == K_NONE) ? M_ILL : 30'b0);
    else begin
      v = v | recipe[c][ph-3];
      if (rop[c][ph-3]) v = v | {alu_tab[opc], 26'b0};
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic def_op(input int opc, input int c, input logic [3:0] op);
    cls_tab[opc] = c;
    alu_tab[opc] = op;
  endtask

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  // Instruction-level model: position within fetch + class recipe, plus the T1 wait count.
  always @(posedge Clock or negedge clear) begin
    if (!clear) begin
      m_phase <= PH_RST;
      m_wait  <= 0;
    end else if (m_phase == PH_RST) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
      m_wait  <= 0;
    end else if (m_phase == 1) begin
      if (bus_if.mem_ready) m_phase <= 2;
      else if (m_wait + 1 == TIMEOUT) m_phase <= PH_FAULT;
      else m_wait <= m_wait + 1;
    end else if (m_phase == 2) begin
      if (cls_tab[bus_if.IR[31:27]] == K_HALT) m_phase <= PH_HALT;
      else if (cls_tab[bus_if.IR[31:27]] == K_NOP || cls_tab[bus_if.IR[31:27]] == K_NONE) m_phase <= 0;
      else m_phase <= 3;
    end else if (m_phase >= 3 && m_phase < PH_HALT) begin
      if (m_phase - 3 == rlen[cls_tab[bus_if.IR[31:27]]] - 1) m_phase <= bus_if.Stop ? PH_HALT : 0;
      else m_phase <= m_phase + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge Clock) begin
    chk($sformatf("cycle ph=%0d", m_phase), 32'(dut_vec()),
        32'(model_vec(m_phase, bus_if.IR, bus_if.mem_ready)));
  end

  task automatic pulse_clear();
    clear = 1'b0;
    #1;
    chk("clear_async_zero", 32'(dut_vec()), 32'h0);
    step();
    clear = 1'b1;
  endtask

  initial begin
    logic stall;
    logic [4:0] ropc;
    stall = 1'b0;
    for (int i = 0; i < 32; i++) def_op(i, K_NONE, 4'd0);
    for (int c = 0; c < 7; c++) begin
      rlen[c] = 0;
      for (int k = 0; k < 4; k++) begin
        recipe[c][k] = 30'b0;
        rop[c][k]    = 1'b0;
      end
    end
    def_op(3, K_REG3, 4'd1);  def_op(4, K_REG3, 4'd2);  def_op(5, K_REG3, 4'd3);
    def_op(6, K_REG3, 4'd4);  def_op(7, K_REG3, 4'd5);  def_op(8, K_REG3, 4'd6);
    def_op(9, K_REG3, 4'd7);  def_op(10, K_REG3, 4'd8); def_op(11, K_IMM, 4'd1);
    def_op(12, K_IMM, 4'd3);  def_op(13, K_IMM, 4'd4);  def_op(15, K_MD, 4'd9);
    def_op(16, K_MD, 4'd10);  def_op(17, K_UN, 4'd11);  def_op(18, K_UN, 4'd12);
    def_op(26, K_NOP, 4'd0);  def_op(27, K_HALT, 4'd0);
    rlen[K_REG3] = 3; rlen[K_IMM] = 3; rlen[K_MD] = 4; rlen[K_UN] = 2;
    recipe[K_REG3][0] = M_GRB | M_ROUT | M_YIN;
    recipe[K_REG3][1] = M_GRC | M_ROUT | M_ZINLO;  rop[K_REG3][1] = 1'b1;
    recipe[K_REG3][2] = M_ZLO | M_GRA | M_RIN;
    recipe[K_IMM][0]  = M_GRB | M_ROUT | M_YIN;
    recipe[K_IMM][1]  = M_COUT | M_ZINLO;          rop[K_IMM][1] = 1'b1;
    recipe[K_IMM][2]  = M_ZLO | M_GRA | M_RIN;
    recipe[K_MD][0]   = M_GRA | M_ROUT | M_YIN;
    recipe[K_MD][1]   = M_GRB | M_ROUT | M_ZINLO | M_ZINHI; rop[K_MD][1] = 1'b1;
    recipe[K_MD][2]   = M_ZLO | M_LOIN;
    recipe[K_MD][3]   = M_ZHI | M_HIIN;
    recipe[K_UN][0]   = M_GRB | M_ROUT | M_ZINLO;  rop[K_UN][0] = 1'b1;
    recipe[K_UN][1]   = M_ZLO | M_GRA | M_RIN;

    clear = 1'b0;
    bus_if.IR = 32'h18918000;
    bus_if.mem_ready = 1'b1;
    bus_if.Stop = 1'b0;
    step(); step();
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    clear = 1'b1;

    // add R1,R2,R3 with immediate memory ready
    step(); chk("add_T0", 32'({bus_if.PCout, bus_if.MARin, bus_if.IncPC, bus_if.Zin_low, bus_if.Run}), 32'h1f);
    step(); chk("add_T1", 32'({bus_if.Read, bus_if.MDRin, bus_if.Zlowout, bus_if.PCin}), 32'hf);
    step(); chk("add_T2", 32'({bus_if.MDRout, bus_if.IRin}), 32'h3);
    step(); chk("add_T3", 32'({bus_if.Grb, bus_if.Rout, bus_if.Yin}), 32'h7);
    step(); chk("add_T4_op", 32'(bus_if.operation), 32'h1);
            chk("add_T4", 32'({bus_if.Grc, bus_if.Rout, bus_if.Zin_low}), 32'h7);
    step(); chk("add_T5", 32'({bus_if.Zlowout, bus_if.Gra, bus_if.Rin}), 32'h7);
    step(); chk("add_back_T0", 32'(bus_if.PCout), 32'h1);

    // same instruction, memory ready only in the 4th T1 cycle
    for (int i = 1; i <= 4; i++) begin
      step();
      bus_if.mem_ready = (i == 4);
      #1;
      chk("wait_read", 32'({bus_if.Read, bus_if.MDRin}), 32'h3);
      chk("wait_pcin", 32'({bus_if.PCin, bus_if.Zlowout}), (i == 4) ? 32'h3 : 32'h0);
    end
    step(); step(); step(); step();
    step(); chk("wait_back_T0", 32'(bus_if.PCout), 32'h1);

    // memory never ready: FAULT after 15 T1 cycles
    bus_if.mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) step();
    chk("to_T1_15", 32'(bus_if.Read), 32'h1);
    step(); chk("fault_vec", 32'(dut_vec()), 32'h0200_0000);
    step(); chk("fault_held", 32'(dut_vec()), 32'h0200_0000);
    bus_if.mem_ready = 1'b1;
    pulse_clear();
    step(); chk("fault_recover_T0", 32'(bus_if.PCout), 32'h1);

    // mul: 7-cycle instruction with Zin_high, LOin, HIin
    bus_if.IR = 32'h78000000;
    step(); step(); step();
    chk("mul_T3", 32'({bus_if.Gra, bus_if.Rout, bus_if.Yin}), 32'h7);
    step(); chk("mul_T4_op", 32'(bus_if.operation), 32'h9);
            chk("mul_T4", 32'({bus_if.Zin_low, bus_if.Zin_high}), 32'h3);
    step(); chk("mul_T5", 32'(bus_if.LOin), 32'h1);
    step(); chk("mul_T6", 32'(bus_if.HIin), 32'h1);
    step(); chk("mul_back_T0", 32'(bus_if.PCout), 32'h1);

    // halt instruction
    bus_if.IR = 32'hD8000000;
    step(); step(); step();
    chk("halt_instr", 32'(dut_vec()), 32'h0);
    pulse_clear();
    step(); chk("halt_recover_T0", 32'(bus_if.PCout), 32'h1);

    // Stop during add's T5
    bus_if.IR = 32'h18918000;
    step(); step(); step(); step(); step();
    bus_if.Stop = 1'b1;
    step(); chk("stop_halt_run", 32'(bus_if.Run), 32'h0);
    bus_if.Stop = 1'b0;
    pulse_clear();
    step();

    // unsupported opcode
    bus_if.IR = 32'hF8000000;
    step(); step(); chk("illegal_T2", 32'(bus_if.illegal_op), 32'h1);
    step(); chk("illegal_next", 32'({bus_if.illegal_op, bus_if.PCout}), 32'h1);

    // clear asserted in the middle of add's T4
    bus_if.IR = 32'h18918000;
    step(); step(); step(); step();
    pulse_clear();
    step();

    // randomised instruction stream
    for (int n = 0; n < 4000; n++) begin
      step();
      if (!clear) clear = 1'b1;
      else if ((m_phase == PH_HALT || m_phase == PH_FAULT) && $urandom_range(0, 3) == 0) clear = 1'b0;
      else if ($urandom_range(0, 299) == 0) clear = 1'b0;
      if (m_phase == 0 || m_phase == PH_RST) begin
        ropc = 5'($urandom_range(0, 31));
        bus_if.IR = {ropc, 27'($urandom)};
        stall = ($urandom_range(0, 24) == 0);
      end
      bus_if.mem_ready = stall ? 1'b0 : ($urandom_range(0, 9) < 4);
      bus_if.Stop = ($urandom_range(0, 9) == 0);
    end

    @(posedge Clock);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
